// File: rtl/sprite_anim_layer_if.sv
// ROM-side bus of the sprite layer: registered address out, palette index back.
interface sprite_anim_layer_if #(
    parameter int ADDR_W = 12,
    parameter int IDX_W  = 3
);
    logic [ADDR_W-1:0] rom_address;
    logic [IDX_W-1:0]  rom_q;

    modport master (output rom_address, input rom_q);
    modport slave  (input rom_address, output rom_q);
endinterface

// File: rtl/sprite_anim_layer.sv
// Animated, movable sprite layer in the VGA pixel domain; 2-cycle pixel latency.
// Optional SPRITE_MIRROR_EN adds mirror_x for a horizontally flipped sprite.
module sprite_anim_layer #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int FRAMES      = 4,
    parameter int FRAME_TICKS = 8,
    parameter int ADDR_W      = 12,
    parameter int IDX_W       = 3,
    parameter int TRANSP_IDX  = 0,
    localparam int AF_W = (FRAMES > 1) ? $clog2(FRAMES) : 1,
    localparam int TK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1
) (
    input  logic                 vga_clk,
    input  logic                 reset,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic                 blank,
    input  logic [9:0]           pos_x,
    input  logic [9:0]           pos_y,
    input  logic                 spr_en,
    input  logic                 anim_run,
`ifdef SPRITE_MIRROR_EN
    input  logic                 mirror_x,
`endif
    sprite_anim_layer_if.master  rom_if,
    output logic [IDX_W-1:0]     pix_idx,
    output logic                 opaque,
    output logic [AF_W-1:0]      anim_frame
);

    if ((64'(1) << ADDR_W) < 64'(SPR_W) * 64'(SPR_H) * 64'(FRAMES)) begin : g_bad_addr_w
        $error("ADDR_W too small for SPR_W*SPR_H*FRAMES");
    end
    if (FRAME_TICKS < 1) begin : g_bad_ticks
        $error("FRAME_TICKS must be >= 1");
    end

    logic [9:0]        sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic              sh_en_q, sh_en_d;
    logic [TK_W-1:0]   tick_q, tick_d;
    logic [AF_W-1:0]   anim_frame_q, anim_frame_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              hit_s1_q, hit_s1_d, blank_s1_q, blank_s1_d;
    logic              opaque_q, opaque_d;
    logic [IDX_W-1:0]  pix_idx_q, pix_idx_d;
`ifdef SPRITE_MIRROR_EN
    logic              sh_mir_q, sh_mir_d;
`endif

    logic        frame_start, hit;
    logic [10:0] dx, dy, sx, sy, col_raw, row_raw;
    logic [31:0] col, row;

    always_comb begin
        sh_x_d       = sh_x_q;
        sh_y_d       = sh_y_q;
        sh_en_d      = sh_en_q;
        tick_d       = tick_q;
        anim_frame_d = anim_frame_q;
`ifdef SPRITE_MIRROR_EN
        sh_mir_d     = sh_mir_q;
`endif
        frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

        if (frame_start) begin
            sh_x_d  = pos_x;
            sh_y_d  = pos_y;
            sh_en_d = spr_en;
`ifdef SPRITE_MIRROR_EN
            sh_mir_d = mirror_x;
`endif
            if (anim_run) begin
                if (tick_q == TK_W'(FRAME_TICKS - 1)) begin
                    tick_d       = '0;
                    anim_frame_d = (anim_frame_q == AF_W'(FRAMES - 1)) ? '0
                                                                       : anim_frame_q + AF_W'(1);
                end else begin
                    tick_d = tick_q + TK_W'(1);
                end
            end
        end

        // 11-bit compares so a sprite near the right/bottom edge clips instead of wrapping
        dx  = {1'b0, DrawX};
        dy  = {1'b0, DrawY};
        sx  = {1'b0, sh_x_q};
        sy  = {1'b0, sh_y_q};
        hit = sh_en_q && (dx >= sx) && (dx < sx + 11'(SPR_W))
                      && (dy >= sy) && (dy < sy + 11'(SPR_H));

        col_raw = dx - sx;
        row_raw = dy - sy;
        row     = 32'(row_raw);
`ifdef SPRITE_MIRROR_EN
        col = sh_mir_q ? (32'(SPR_W - 1) - 32'(col_raw)) : 32'(col_raw);
`else
        col = 32'(col_raw);
`endif

        rom_addr_d = hit ? ADDR_W'(32'(anim_frame_q) * 32'(SPR_W * SPR_H) + row * 32'(SPR_W) + col)
                         : '0;
        hit_s1_d   = hit;
        blank_s1_d = blank;

        opaque_d  = hit_s1_q && blank_s1_q && (rom_if.rom_q != IDX_W'(TRANSP_IDX));
        pix_idx_d = opaque_d ? rom_if.rom_q : '0;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            sh_x_q       <= '0;
            sh_y_q       <= '0;
            sh_en_q      <= 1'b0;
            tick_q       <= '0;
            anim_frame_q <= '0;
            rom_addr_q   <= '0;
            hit_s1_q     <= 1'b0;
            blank_s1_q   <= 1'b0;
            opaque_q     <= 1'b0;
            pix_idx_q    <= '0;
`ifdef SPRITE_MIRROR_EN
            sh_mir_q     <= 1'b0;
`endif
        end else begin
            sh_x_q       <= sh_x_d;
            sh_y_q       <= sh_y_d;
            sh_en_q      <= sh_en_d;
            tick_q       <= tick_d;
            anim_frame_q <= anim_frame_d;
            rom_addr_q   <= rom_addr_d;
            hit_s1_q     <= hit_s1_d;
            blank_s1_q   <= blank_s1_d;
            opaque_q     <= opaque_d;
            pix_idx_q    <= pix_idx_d;
`ifdef SPRITE_MIRROR_EN
            sh_mir_q     <= sh_mir_d;
`endif
        end
    end

    assign rom_if.rom_address = rom_addr_q;
    assign pix_idx            = pix_idx_q;
    assign opaque             = opaque_q;
    assign anim_frame         = anim_frame_q;

endmodule
